// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: issue/ALU/writeback bundle; master = issue controller, slave = pipeline and ALU
interface alu_issue_ctrl_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_opcode;
  logic [5:0]       in_funct;
  logic [4:0]       in_shamt;
  logic [4:0]       in_rt;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [4:0]       op_select;
  logic [4:0]       alu_ir;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_result_hi;
  logic             alu_branch_taken;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_write;
  logic             out_branch;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (
    input  in_valid, in_opcode, in_funct, in_shamt, in_rt, in_a, in_b,
           alu_result, alu_result_hi, alu_branch_taken, out_ready,
    output in_ready, op_select, alu_ir, alu_in1, alu_in2,
           out_valid, out_result, out_write, out_branch, hi, lo
  );
  modport slave (
    output in_valid, in_opcode, in_funct, in_shamt, in_rt, in_a, in_b,
           alu_result, alu_result_hi, alu_branch_taken, out_ready,
    input  in_ready, op_select, alu_ir, alu_in1, alu_in2,
           out_valid, out_result, out_write, out_branch, hi, lo
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one MIPS instruction per handshake, drives the ALU, owns HI/LO, holds result for writeback (ports: clk, rst, bus master modport, out_illegal only with ALU_ILLEGAL_TRAP_EN)
module alu_issue_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
`ifdef ALU_ILLEGAL_TRAP_EN
  output logic              out_illegal,
`endif
  alu_issue_ctrl_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MWAIT, S_DONE} state_t;
  localparam logic [2:0] K_ALU  = 3'd0;
  localparam logic [2:0] K_MULT = 3'd1;
  localparam logic [2:0] K_MFHI = 3'd2;
  localparam logic [2:0] K_MFLO = 3'd3;
  localparam logic [2:0] K_JR   = 3'd4;
  localparam logic [2:0] K_BR   = 3'd5;
  localparam logic [2:0] K_ILL  = 3'd6;
  localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MULT_CYCLES == 0) ? '0 : CW'(MULT_CYCLES - 1);
  state_t             state, state_nx;
  logic [4:0]         dec_op;
  logic [2:0]         dec_kind, kind;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  always_comb begin
    {dec_op, dec_kind} = {5'h00, K_ILL};
    if (bus.in_opcode == 6'h00)
      case (bus.in_funct)
        6'h21: {dec_op, dec_kind} = {5'h00, K_ALU};
        6'h23: {dec_op, dec_kind} = {5'h01, K_ALU};
        6'h18: {dec_op, dec_kind} = {5'h02, K_MULT};
        6'h19: {dec_op, dec_kind} = {5'h03, K_MULT};
        6'h24: {dec_op, dec_kind} = {5'h04, K_ALU};
        6'h25: {dec_op, dec_kind} = {5'h05, K_ALU};
        6'h26: {dec_op, dec_kind} = {5'h06, K_ALU};
        6'h02: {dec_op, dec_kind} = {5'h07, K_ALU};
        6'h00: {dec_op, dec_kind} = {5'h08, K_ALU};
        6'h03: {dec_op, dec_kind} = {5'h09, K_ALU};
        6'h2A: {dec_op, dec_kind} = {5'h0A, K_ALU};
        6'h2B: {dec_op, dec_kind} = {5'h0B, K_ALU};
        6'h08: {dec_op, dec_kind} = {5'h12, K_JR};
        6'h10: {dec_op, dec_kind} = {5'h00, K_MFHI};
        6'h12: {dec_op, dec_kind} = {5'h00, K_MFLO};
        default: {dec_op, dec_kind} = {5'h00, K_ILL};
      endcase
    else
      case (bus.in_opcode)
        6'h09: {dec_op, dec_kind} = {5'h00, K_ALU};
        6'h0C: {dec_op, dec_kind} = {5'h04, K_ALU};
        6'h0D: {dec_op, dec_kind} = {5'h05, K_ALU};
        6'h0E: {dec_op, dec_kind} = {5'h06, K_ALU};
        6'h0A: {dec_op, dec_kind} = {5'h0A, K_ALU};
        6'h0B: {dec_op, dec_kind} = {5'h0B, K_ALU};
        6'h04: {dec_op, dec_kind} = {5'h0C, K_BR};
        6'h05: {dec_op, dec_kind} = {5'h0D, K_BR};
        6'h06: {dec_op, dec_kind} = {5'h0E, K_BR};
        6'h07: {dec_op, dec_kind} = {5'h0F, K_BR};
        6'h01: {dec_op, dec_kind} = bus.in_rt == 5'd0 ? {5'h10, K_BR}
                                  : bus.in_rt == 5'd1 ? {5'h11, K_BR} : {5'h00, K_ILL};
        default: {dec_op, dec_kind} = {5'h00, K_ILL};
      endcase
  end
  always_comb begin
    state_nx = state == S_IDLE  ? (bus.in_valid ? S_EXEC : S_IDLE)
             : state == S_EXEC  ? ((kind == K_MULT && MULT_CYCLES > 0) ? S_MWAIT : S_DONE)
             : state == S_MWAIT ? (cnt == '0 ? S_DONE : S_MWAIT)
             : (bus.out_ready ? S_IDLE : S_DONE);
  end
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_nx;
  assign bus.in_ready  = state == S_IDLE;
  assign bus.out_valid = state == S_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.op_select  <= '0;
      bus.alu_ir     <= '0;
      bus.alu_in1    <= '0;
      bus.alu_in2    <= '0;
      bus.out_result <= '0;
      bus.out_write  <= 1'b0;
      bus.out_branch <= 1'b0;
      bus.hi         <= '0;
      bus.lo         <= '0;
      kind           <= K_ALU;
      cnt            <= '0;
      prod           <= '0;
`ifdef ALU_ILLEGAL_TRAP_EN
      out_illegal    <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && bus.in_valid) begin
        bus.op_select <= dec_op;
        bus.alu_ir    <= bus.in_shamt;
        bus.alu_in1   <= bus.in_a;
        bus.alu_in2   <= bus.in_b;
        kind          <= dec_kind;
      end
      if (state == S_EXEC) begin
        prod           <= {bus.alu_result_hi, bus.alu_result};
        cnt            <= CNT_LOAD;
        // without wait cycles the product commits here; out_result already carries lo
        if (kind == K_MULT && MULT_CYCLES == 0)
          {bus.hi, bus.lo} <= {bus.alu_result_hi, bus.alu_result};
        bus.out_result <= kind == K_MFHI ? bus.hi
                        : kind == K_MFLO ? bus.lo
                        : (kind == K_BR || kind == K_ILL) ? '0 : bus.alu_result;
        bus.out_write  <= kind == K_ALU || kind == K_MFHI || kind == K_MFLO;
        bus.out_branch <= kind == K_BR && bus.alu_branch_taken;
`ifdef ALU_ILLEGAL_TRAP_EN
        out_illegal    <= kind == K_ILL;
`endif
      end
      if (state == S_MWAIT) begin
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          {bus.hi, bus.lo} <= prod;
          bus.out_result   <= prod[WIDTH-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench with a behavioural ALU attached to the controller
module tb_alu_issue_ctrl;
  localparam int MC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   lat;
  always #5 clk = ~clk;
  alu_issue_ctrl_if #(.WIDTH(32)) bus ();
`ifdef ALU_ILLEGAL_TRAP_EN
  logic ill;
  alu_issue_ctrl #(.WIDTH(32), .MULT_CYCLES(MC)) dut (.clk(clk), .rst(rst), .out_illegal(ill), .bus(bus.master));
`else
  alu_issue_ctrl #(.WIDTH(32), .MULT_CYCLES(MC)) dut (.clk(clk), .rst(rst), .bus(bus.master));
`endif
  logic [31:0] a, b;
  logic [63:0] p;
  assign a = bus.alu_in1;
  assign b = bus.alu_in2;
  always_comb begin
    p = 64'd0;
    bus.alu_branch_taken = 1'b0;
    case (bus.op_select)
      5'h00: p[31:0] = a + b;
      5'h01: p[31:0] = a - b;
      5'h02: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      5'h03: p = {32'd0, a} * {32'd0, b};
      5'h04: p[31:0] = a & b;
      5'h05: p[31:0] = a | b;
      5'h06: p[31:0] = a ^ b;
      5'h07: p[31:0] = b >> bus.alu_ir;
      5'h08: p[31:0] = b << bus.alu_ir;
      5'h09: p[31:0] = $signed(b) >>> bus.alu_ir;
      5'h0A: p[31:0] = {31'd0, $signed(a) < $signed(b)};
      5'h0B: p[31:0] = {31'd0, a < b};
      5'h0C: bus.alu_branch_taken = a == b;
      5'h0D: bus.alu_branch_taken = a != b;
      5'h0E: bus.alu_branch_taken = $signed(a) <= 0;
      5'h0F: bus.alu_branch_taken = $signed(a) > 0;
      5'h10: bus.alu_branch_taken = a[31];
      5'h11: bus.alu_branch_taken = ~a[31];
      5'h12: p[31:0] = a;
      default: p = 64'd0;
    endcase
  end
  assign bus.alu_result    = p[31:0];
  assign bus.alu_result_hi = p[63:32];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [4:0] rt, input logic [31:0] ia, input logic [31:0] ib);
    bus.in_opcode = op;
    bus.in_funct  = fn;
    bus.in_shamt  = sh;
    bus.in_rt     = rt;
    bus.in_a      = ia;
    bus.in_b      = ib;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic consume;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_opcode = '0;
    bus.in_funct = '0;
    bus.in_shamt = '0;
    bus.in_rt = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_hilo", {bus.hi, bus.lo}, 0);
    chk("rst_op_select", bus.op_select, 0);
    chk("rst_out", {bus.out_result, bus.out_write, bus.out_branch}, 0);
    issue(6'h00, 6'h21, 0, 0, 5, 7);
    chk("addu_pending", bus.out_valid, 0);
    wait_done(lat);
    chk("addu_lat", lat, 1);
    chk("addu_res", bus.out_result, 12);
    chk("addu_wr_br", {bus.out_write, bus.out_branch}, 2'b10);
    chk("addu_opsel", bus.op_select, 5'h00);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("addu_illegal", ill, 0);
`endif
    consume;
    chk("idle_after_consume", bus.in_ready, 1);
    issue(6'h00, 6'h18, 0, 0, 32'hFFFF_FFFD, 4);
    wait_done(lat);
    chk("mult_lat", lat, 1 + MC);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFF4);
    chk("mult_res", bus.out_result, 32'hFFFF_FFF4);
    chk("mult_wr", bus.out_write, 0);
    chk("mult_opsel", bus.op_select, 5'h02);
    consume;
    issue(6'h00, 6'h10, 0, 0, 1, 2);
    wait_done(lat);
    chk("mfhi_res", bus.out_result, 32'hFFFF_FFFF);
    chk("mfhi_wr", bus.out_write, 1);
    consume;
    issue(6'h04, 0, 0, 0, 9, 9);
    wait_done(lat);
    chk("beq_br_wr", {bus.out_branch, bus.out_write}, 2'b10);
    chk("beq_res", bus.out_result, 0);
    chk("beq_opsel", bus.op_select, 5'h0C);
    consume;
    issue(6'h01, 0, 0, 5'd0, 32'h8000_0000, 0);
    wait_done(lat);
    chk("bltz_br", bus.out_branch, 1);
    chk("bltz_opsel", bus.op_select, 5'h10);
    consume;
    issue(6'h01, 0, 0, 5'd1, 32'h8000_0000, 0);
    wait_done(lat);
    chk("bgez_br", bus.out_branch, 0);
    chk("bgez_opsel", bus.op_select, 5'h11);
    consume;
    issue(6'h00, 6'h23, 0, 0, 3, 5);
    wait_done(lat);
    chk("subu_res", bus.out_result, 32'hFFFF_FFFE);
    consume;
    issue(6'h0D, 0, 0, 0, 32'hF0, 32'h0F);
    wait_done(lat);
    chk("ori_res", bus.out_result, 32'hFF);
    chk("ori_opsel", bus.op_select, 5'h05);
    consume;
    issue(6'h00, 6'h08, 0, 0, 32'h0040_0100, 0);
    wait_done(lat);
    chk("jr_res", bus.out_result, 32'h0040_0100);
    chk("jr_wr", bus.out_write, 0);
    chk("jr_opsel", bus.op_select, 5'h12);
    consume;
    issue(6'h00, 6'h03, 5'd4, 0, 0, 32'h8000_0000);
    wait_done(lat);
    chk("sra_res", bus.out_result, 32'hF800_0000);
    chk("sra_ir", bus.alu_ir, 4);
    for (int i = 0; i < 5; i++) begin
      bus.in_opcode = 6'h00;
      bus.in_funct  = 6'h18;
      bus.in_a      = 32'h1234 + i;
      bus.in_b      = 32'h10;
      bus.in_valid  = i[0];
      @(negedge clk);
      chk("hold_state", {bus.out_valid, bus.in_ready, bus.out_write}, 3'b101);
      chk("hold_res", bus.out_result, 32'hF800_0000);
    end
    bus.in_valid = 1'b0;
    consume;
    @(negedge clk);
    chk("no_ghost_op", {bus.out_valid, bus.in_ready}, 2'b01);
    chk("no_ghost_hi", bus.hi, 32'hFFFF_FFFF);
    issue(6'h3F, 0, 0, 0, 3, 4);
    wait_done(lat);
    chk("illegal_lat", lat, 1);
    chk("illegal_out", {bus.out_result, bus.out_write, bus.out_branch}, 0);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("illegal_flag", ill, 1);
`endif
    consume;
    issue(6'h00, 6'h19, 0, 0, 32'hFFFF_FFFF, 2);
    wait_done(lat);
    chk("multu_hilo", {bus.hi, bus.lo}, 64'h1_FFFF_FFFE);
    consume;
    issue(6'h00, 6'h12, 0, 0, 0, 0);
    wait_done(lat);
    chk("mflo_res", bus.out_result, 32'hFFFF_FFFE);
    consume;
    issue(6'h00, 6'h18, 0, 0, 2, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_hilo", {bus.hi, bus.lo}, 0);
    chk("midrst_flags", {bus.out_valid, bus.in_ready}, 2'b01);
    repeat (4) @(negedge clk);
    chk("midrst_no_commit", {bus.hi, bus.lo, bus.out_valid}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
